// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipeline: stage stall/flush,
// EX forwarding selects, data-memory wait freeze with watchdog, and perf counters.
module hazard_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             regwriteE,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             memtoregE,
  input  logic             memreqM,
  input  logic             dmem_ready,
  input  logic             pcsrcE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             stallM,
  output logic             stallW,
  output logic             flushF,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

  state_t           r_state;
  logic [WC_W-1:0]  r_wcnt;
  logic             r_halted;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_wait_now, w_lduse, w_branch, w_any_stall;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (regwriteM && rdM != 5'd0 && rdM == rs)      return 2'b10;
    else if (regwriteW && rdW != 5'd0 && rdW == rs) return 2'b01;
    else                                            return 2'b00;
  endfunction

  assign w_wait_now = memreqM & ~dmem_ready;
  assign w_lduse    = memtoregE & regwriteE & (rdE != 5'd0) & ((rdE == rs1D) | (rdE == rs2D));

  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (!reset) begin
      forwardAE = fwd_sel(rs1E);
      forwardBE = fwd_sel(rs2E);
    end
  end

  // RUN and MEM_WAIT share outputs: both freeze on wait_now and run normally otherwise.
  always_comb begin
    {stallF, stallD, stallE, stallM, stallW} = 5'b0;
    {flushF, flushD, flushE, flushM, flushW} = 5'b0;
    w_branch = 1'b0;
    if (reset) begin
      {flushF, flushD, flushE, flushM, flushW} = 5'b11111;
    end else if (r_state == HALT) begin
      {stallF, stallD, stallE, stallM, stallW} = 5'b11111;
      flushW = 1'b1;
    end else if (w_wait_now) begin
      {stallF, stallD, stallE, stallM} = 4'b1111;
      flushW = 1'b1;
    end else if (pcsrcE) begin
      flushD   = 1'b1;
      flushE   = 1'b1;
      w_branch = 1'b1;
    end else if (w_lduse) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
  end

  assign w_any_stall = stallF | stallD | stallE | stallM | stallW;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= RUN;
      r_wcnt      <= '0;
      r_halted    <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        RUN, MEM_WAIT: begin
          if (w_wait_now) begin
            // r_wcnt holds the wait cycles already elapsed; this is the last allowed one.
            if (r_wcnt == WC_W'(TIMEOUT - 1)) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
              r_wcnt   <= '0;
            end else begin
              r_state <= MEM_WAIT;
              r_wcnt  <= r_wcnt + 1'b1;
            end
          end else begin
            r_state <= RUN;
            r_wcnt  <= '0;
          end
        end
        HALT:    r_state <= HALT;
        default: r_state <= RUN;
      endcase
      if (w_any_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_branch && !(&r_flush_cnt))    r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign halted       = r_halted;
  assign stall_cycles = r_stall_cnt;
  assign flush_count  = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic checked against
// a cycle-level reference model; a second instance with 2-bit counters checks saturation.
module tb_hazard_ctrl;
  localparam int TO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic       regwriteE, regwriteM, regwriteW, memtoregE, memreqM, dmem_ready, pcsrcE;

  logic        stallF, stallD, stallE, stallM, stallW;
  logic        flushF, flushD, flushE, flushM, flushW;
  logic [1:0]  forwardAE, forwardBE;
  logic        halted;
  logic [31:0] stall_cycles, flush_count;

  logic        s_stallF, s_stallD, s_stallE, s_stallM, s_stallW;
  logic        s_flushF, s_flushD, s_flushE, s_flushM, s_flushW;
  logic [1:0]  s_forwardAE, s_forwardBE;
  logic        s_halted;
  logic [1:0]  s_stall_cycles, s_flush_count;

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .memtoregE(memtoregE), .memreqM(memreqM),
    .dmem_ready(dmem_ready), .pcsrcE(pcsrcE),
    .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
    .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .halted(halted),
    .stall_cycles(stall_cycles), .flush_count(flush_count));

  hazard_ctrl #(.TIMEOUT(TO), .CNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW), .regwriteE(regwriteE), .regwriteM(regwriteM),
    .regwriteW(regwriteW), .memtoregE(memtoregE), .memreqM(memreqM),
    .dmem_ready(dmem_ready), .pcsrcE(pcsrcE),
    .stallF(s_stallF), .stallD(s_stallD), .stallE(s_stallE), .stallM(s_stallM), .stallW(s_stallW),
    .flushF(s_flushF), .flushD(s_flushD), .flushE(s_flushE), .flushM(s_flushM), .flushW(s_flushW),
    .forwardAE(s_forwardAE), .forwardBE(s_forwardBE), .halted(s_halted),
    .stall_cycles(s_stall_cycles), .flush_count(s_flush_count));

  wire [9:0] ctl   = {stallF, stallD, stallE, stallM, stallW, flushF, flushD, flushE, flushM, flushW};
  wire [9:0] s_ctl = {s_stallF, s_stallD, s_stallE, s_stallM, s_stallW,
                      s_flushF, s_flushD, s_flushE, s_flushM, s_flushW};

  localparam logic [9:0] C_RST  = 10'b00000_11111;
  localparam logic [9:0] C_HALT = 10'b11111_00001;
  localparam logic [9:0] C_WAIT = 10'b11110_00001;
  localparam logic [9:0] C_BR   = 10'b00000_01100;
  localparam logic [9:0] C_LU   = 10'b11000_00100;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: consecutive-wait length, halted flag, unbounded event counts.
  int     m_waits;
  bit     m_halted;
  longint m_stall, m_flush;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
    if (reset) return 2'b00;
    if (regwriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (regwriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [9:0] ref_ctl();
    bit lu;
    lu = memtoregE && regwriteE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    if (reset)                    return C_RST;
    if (m_halted)                 return C_HALT;
    if (memreqM && !dmem_ready)   return C_WAIT;
    if (pcsrcE)                   return C_BR;
    if (lu)                       return C_LU;
    return 10'b0;
  endfunction

  function automatic logic [1:0] sat2(input longint v);
    return (v > 3) ? 2'd3 : v[1:0];
  endfunction

  task automatic tick();
    logic [9:0] c;
    @(posedge clk);
    c = ref_ctl();
    if (reset) begin
      m_waits = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (c[9:5] != 0) m_stall++;
      if (c == C_BR)   m_flush++;
      if (!m_halted) begin
        if (memreqM && !dmem_ready) begin
          m_waits++;
          if (m_waits == TO) begin m_halted = 1; m_waits = 0; end
        end else m_waits = 0;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {regwriteE, regwriteM, regwriteW, memtoregE, memreqM, dmem_ready, pcsrcE} = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear_inputs();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    regwriteM = 1'b1; rdM = 5'd9; rs1E = 5'd9; rs2E = 5'd9;
    @(negedge clk);
    n_tests++; if (ctl !== C_RST) begin n_fail++; $display("FAIL reset_ctl: got %b want %b", ctl, C_RST); end
    n_tests++; if (forwardAE !== 2'b00 || forwardBE !== 2'b00) begin n_fail++;
      $display("FAIL reset_fwd: got %b/%b want 00/00", forwardAE, forwardBE); end
    tick();
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    n_tests++; if (stall_cycles !== 0 || flush_count !== 0 || halted !== 1'b0) begin n_fail++;
      $display("FAIL reset_state: got %0d/%0d/%b want 0/0/0", stall_cycles, flush_count, halted); end
    n_tests++; if (ctl !== 10'b0) begin n_fail++; $display("FAIL reset_idle_ctl: got %b want 0", ctl); end
    tick();
  endtask

  task automatic test_forwarding();
    do_reset();
    regwriteM = 1; rdM = 5; rs1E = 5; regwriteW = 1; rdW = 5;
    @(negedge clk);
    n_tests++; if (forwardAE !== 2'b10) begin n_fail++; $display("FAIL fwd_mem: got %b want 10", forwardAE); end
    rdM = 6; #1;
    n_tests++; if (forwardAE !== 2'b01) begin n_fail++; $display("FAIL fwd_wb: got %b want 01", forwardAE); end
    rdM = 0; rdW = 0; #1;
    n_tests++; if (forwardAE !== 2'b00) begin n_fail++; $display("FAIL fwd_x0: got %b want 00", forwardAE); end
    rs2E = 7; rdW = 7; rdM = 7; regwriteM = 0; #1;
    n_tests++; if (forwardBE !== 2'b01) begin n_fail++; $display("FAIL fwd_b: got %b want 01", forwardBE); end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    memtoregE = 1; regwriteE = 1; rdE = 3; rs2D = 3;
    @(negedge clk);
    n_tests++; if (ctl !== C_LU) begin n_fail++; $display("FAIL lu_ctl: got %b want %b", ctl, C_LU); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_tests++; if (stall_cycles !== 1) begin n_fail++; $display("FAIL lu_cnt: got %0d want 1", stall_cycles); end
    tick();
  endtask

  task automatic test_branch();
    do_reset();
    memtoregE = 1; regwriteE = 1; rdE = 3; rs2D = 3; pcsrcE = 1;
    @(negedge clk);
    n_tests++; if (ctl !== C_BR) begin n_fail++; $display("FAIL br_ctl: got %b want %b", ctl, C_BR); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_tests++; if (flush_count !== 1 || stall_cycles !== 0) begin n_fail++;
      $display("FAIL br_cnt: got %0d/%0d want 1/0", flush_count, stall_cycles); end
    tick();
  endtask

  task automatic test_mem_wait();
    do_reset();
    memreqM = 1; dmem_ready = 1;
    @(negedge clk);
    n_tests++; if (ctl !== 10'b0) begin n_fail++; $display("FAIL mem_ready_now: got %b want 0", ctl); end
    tick();
    dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_tests++; if (ctl !== C_WAIT) begin n_fail++; $display("FAIL mem_wait_ctl%0d: got %b want %b", i, ctl, C_WAIT); end
      tick();
    end
    dmem_ready = 1;
    @(negedge clk);
    n_tests++; if (ctl !== 10'b0) begin n_fail++; $display("FAIL mem_done_ctl: got %b want 0", ctl); end
    tick();
    clear_inputs();
    @(negedge clk);
    n_tests++; if (stall_cycles !== 3 || halted !== 1'b0) begin n_fail++;
      $display("FAIL mem_cnt: got %0d/%b want 3/0", stall_cycles, halted); end
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    memreqM = 1;
    for (int i = 0; i < TO; i++) begin
      @(negedge clk);
      n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL to_early%0d: got %b want 0", i, halted); end
      tick();
    end
    @(negedge clk);
    n_tests++; if (halted !== 1'b1 || ctl !== C_HALT) begin n_fail++;
      $display("FAIL to_halt: got %b/%b want 1/%b", halted, ctl, C_HALT); end
    dmem_ready = 1;
    tick();
    @(negedge clk);
    n_tests++; if (halted !== 1'b1 || ctl !== C_HALT) begin n_fail++;
      $display("FAIL to_sticky: got %b/%b want 1/%b", halted, ctl, C_HALT); end
    do_reset();
    @(negedge clk);
    n_tests++; if (halted !== 1'b0 || ctl !== 10'b0) begin n_fail++;
      $display("FAIL to_clear: got %b/%b want 0/0", halted, ctl); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    do_reset();
    memreqM = 1;
    tick(); tick();
    reset = 1;
    @(negedge clk);
    n_tests++; if (ctl !== C_RST) begin n_fail++; $display("FAIL rmw_ctl: got %b want %b", ctl, C_RST); end
    tick();
    reset = 0; memreqM = 0;
    @(negedge clk);
    n_tests++; if (ctl !== 10'b0 || stall_cycles !== 0 || flush_count !== 0) begin n_fail++;
      $display("FAIL rmw_run: got %b/%0d/%0d want 0/0/0", ctl, stall_cycles, flush_count); end
    tick();
    // A fresh wait must count from zero after the discarded one.
    memreqM = 1;
    tick(); tick(); tick();
    @(negedge clk);
    n_tests++; if (halted !== 1'b0) begin n_fail++; $display("FAIL rmw_wcnt: got %b want 0", halted); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    memtoregE = 1; regwriteE = 1; rdE = 3; rs1D = 3;
    for (int i = 0; i < 5; i++) tick();
    clear_inputs();
    @(negedge clk);
    n_tests++; if (s_stall_cycles !== 2'd3) begin n_fail++; $display("FAIL sat_stall: got %0d want 3", s_stall_cycles); end
    n_tests++; if (stall_cycles !== 5) begin n_fail++; $display("FAIL sat_wide: got %0d want 5", stall_cycles); end
    tick();
  endtask

  task automatic test_random();
    logic [9:0] ec;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 99) < 2);
      rs1D = 5'($urandom_range(0, 3)); rs2D = 5'($urandom_range(0, 3));
      rs1E = 5'($urandom_range(0, 3)); rs2E = 5'($urandom_range(0, 3));
      rdE  = 5'($urandom_range(0, 3)); rdM  = 5'($urandom_range(0, 3)); rdW = 5'($urandom_range(0, 3));
      regwriteE  = 1'($urandom_range(0, 1)); regwriteM = 1'($urandom_range(0, 1));
      regwriteW  = 1'($urandom_range(0, 1)); memtoregE = 1'($urandom_range(0, 1));
      memreqM    = ($urandom_range(0, 99) < 40);
      dmem_ready = ($urandom_range(0, 99) < 45);
      pcsrcE     = ($urandom_range(0, 99) < 20);
      @(negedge clk);
      ec = ref_ctl();
      n_tests++; if (ctl !== ec || s_ctl !== ec) begin n_fail++;
        if (n_fail < 20) $display("FAIL rnd_ctl@%0d: got %b/%b want %b", i, ctl, s_ctl, ec); end
      n_tests++; if (forwardAE !== ref_fwd(rs1E) || forwardBE !== ref_fwd(rs2E)) begin n_fail++;
        if (n_fail < 20) $display("FAIL rnd_fwd@%0d: got %b/%b want %b/%b", i, forwardAE, forwardBE,
                                  ref_fwd(rs1E), ref_fwd(rs2E)); end
      n_tests++; if (halted !== m_halted || stall_cycles !== 32'(m_stall) || flush_count !== 32'(m_flush)) begin
        n_fail++;
        if (n_fail < 20) $display("FAIL rnd_state@%0d: got %b/%0d/%0d want %b/%0d/%0d", i, halted,
                                  stall_cycles, flush_count, m_halted, m_stall, m_flush); end
      n_tests++; if (s_stall_cycles !== sat2(m_stall) || s_flush_count !== sat2(m_flush)) begin n_fail++;
        if (n_fail < 20) $display("FAIL rnd_sat@%0d: got %0d/%0d want %0d/%0d", i, s_stall_cycles,
                                  s_flush_count, sat2(m_stall), sat2(m_flush)); end
      tick();
    end
    reset = 1'b0;
  endtask

  initial begin
    m_waits = 0; m_halted = 0; m_stall = 0; m_flush = 0;
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    test_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32I core. It drives the `en` (stall, active-high hold) and `clear` (flush) inputs of the pc_if, IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. It also generates the EX-stage forwarding selects and freezes the pipeline while a data-memory access waits for `dmem_ready`, using a watchdog that halts the core on timeout. It owns two saturating performance counters: stall cycles and branch flushes.

## Interface
- `TIMEOUT`, 64: maximum consecutive wait cycles for one data-memory access before the core halts.
- `CNT_W`, 32: width of each performance counter.

- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `rs1D`, `rs2D`  in  5 each  source registers of the instruction in decode.
- `rs1E`, `rs2E`, `rdE`  in  5 each  source and destination registers in execute.
- `rdM`, `rdW`  in  5 each  destination registers in mem and writeback.
- `regwriteE`, `regwriteM`, `regwriteW`  in  1 each  register-write enables per stage.
- `memtoregE`  in  1  the instruction in execute is a load.
- `memreqM`  in  1  the instruction in mem accesses data memory (load or store).
- `dmem_ready`  in  1  data memory completes the access this cycle.
- `pcsrcE`  in  1  branch or jump taken, resolved in execute.
- `stallF`, `stallD`, `stallE`, `stallM`, `stallW`  out  1 each  drive the stage `en` inputs; 1 holds the stage.
- `flushF`, `flushD`, `flushE`, `flushM`, `flushW`  out  1 each  drive the stage `clear` inputs.
- `forwardAE`, `forwardBE`  out  2 each  ALU operand select: 00 register file, 10 ALU result from mem, 01 result from writeback.
- `halted`  out  1  sticky flag: the memory watchdog expired.
- `stall_cycles`  out  CNT_W  count of cycles with any stall.
- `flush_count`  out  CNT_W  count of branch flushes.

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Reset enters RUN.
- A destination of x0 never matches a source register for any hazard check.
- **Forwarding (combinational, every state):**
  - `forwardAE` = 10 if `regwriteM` and `rdM` equals `rs1E`.
  - Otherwise `forwardAE` = 01 if `regwriteW` and `rdW` equals `rs1E`.
  - Otherwise `forwardAE` = 00.
  - `forwardBE` is computed the same way against `rs2E`.
  - Mem has priority over writeback.
- **wait_now** = `memreqM` and not `dmem_ready`.
- **RUN with wait_now = 1:**
  - `stallF`, `stallD`, `stallE`, `stallM` = 1; `flushW` = 1.
  - Load-use and branch actions are suppressed.
  - Next state is MEM_WAIT.
- **MEM_WAIT:** outputs are the same as RUN with wait_now = 1.
  - The wait counter increments each cycle that wait_now holds.
  - When `dmem_ready` = 1, outputs are normal RUN outputs this cycle, the wait counter clears, and the next state is RUN.
  - If the wait counter equals TIMEOUT-1 and wait_now still holds, the next state is HALT.
- **HALT:** all stall outputs = 1, `flushW` = 1, `halted` = 1. The block leaves HALT only on `reset`.
- **RUN with wait_now = 0:**
  - Load-use hazard (`memtoregE`, `regwriteE`, and `rdE` equals `rs1D` or `rs2D`): `stallF` = `stallD` = 1, `flushE` = 1.
  - `pcsrcE` = 1: `flushD` = `flushE` = 1, no stalls. Branch takes precedence over load-use in the same cycle, because the decode instruction is wrong-path.
- **Counters** (no wrap, saturate at all-ones):
  - `stall_cycles` increments each cycle in which any stall output is 1, including HALT.
  - `flush_count` increments on each cycle in which a branch flush is applied.
- A branch that arrives during a memory wait is held frozen in execute and is applied in the first non-stalled cycle.

## Timing
- Forwarding, stall and flush outputs are combinational from the inputs and the current state; there is no added latency.
- State, the wait counter, `halted` and both counters are registered.
- **While `reset` = 1:**
  - `flushF`, `flushD`, `flushE`, `flushM`, `flushW` = 1.
  - All stall outputs = 0.
  - `forwardAE` = `forwardBE` = 00.
- **First clock edge with `reset` = 1:** state = RUN, wait counter = 0, `halted` = 0, `stall_cycles` = 0, `flush_count` = 0.
- `flushF` is 1 only while in reset.
- A reset during MEM_WAIT or HALT returns the block to RUN on the next edge and discards the pending wait.
- An access with `dmem_ready` already high in its first mem cycle causes zero stall cycles.
- An access that waits N cycles (N < TIMEOUT) produces exactly N stall cycles.

## Test plan
- **Forwarding:** `regwriteM`=1, `rdM`=5, `rs1E`=5, `regwriteW`=1, `rdW`=5 -> `forwardAE`=10. Then `rdM`=6 -> `forwardAE`=01. With `rdM`=`rdW`=0 -> `forwardAE`=00.
- **Load-use:** `memtoregE`=1, `regwriteE`=1, `rdE`=3, `rs2D`=3 -> `stallF`=`stallD`=`flushE`=1 for one cycle; `stall_cycles` goes 0 -> 1.
- **Branch vs load-use:** the load-use case above plus `pcsrcE`=1 -> `flushD`=`flushE`=1, `stallF`=`stallD`=0; `flush_count`=1.
- **Memory wait:** `memreqM`=1 with `dmem_ready` low for 3 cycles, then high -> `stallF`..`stallM`=1 and `flushW`=1 for exactly 3 cycles; state returns to RUN; `stall_cycles`=3.
- **Timeout:** `TIMEOUT`=4, `dmem_ready` held low -> `halted`=1 after the 4th wait cycle; it stays 1 with `dmem_ready` later high, and clears only after `reset`.
- **Reset mid-wait and saturation:** assert `reset` during MEM_WAIT -> all flushes=1, and the next cycle is RUN with counters 0. With `CNT_W`=2 and 5 stall cycles -> `stall_cycles`=3.
